// File: rtl/stage3_integration.sv
// Execute stage (stage 3) of the 16-bit JALA pipeline.
// Combinational ALU, ALU/shifter result mux, write-enabled result register
// and a combinational zero flag on the ALU result.
// Optional build macro STAGE3_OVERFLOW_FLAG_EN adds a combinational signed
// overflow flag for add (ALUop 2) and subtract (ALUop 6).
module stage3_integration #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] ShifterOut,
  input  logic [WIDTH-1:0] ALUInA,
  input  logic [WIDTH-1:0] ALUInB,
  input  logic [3:0]       ALUop,
  input  logic             ResSource,
  input  logic             ResWrite,
`ifdef STAGE3_OVERFLOW_FLAG_EN
  output logic             Overflow,
`endif
  output logic [WIDTH-1:0] ResOut,
  output logic             isZero
);

  logic [WIDTH-1:0] alu_sum;
  logic [WIDTH-1:0] alu_diff;
  logic             lt_unsigned;
  logic             lt_signed;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] res_sel;
  logic [WIDTH-1:0] res_out_d;
  logic [WIDTH-1:0] res_out_q;

  // Shared adder/subtractor and comparators; carries are dropped (mod 2^WIDTH).
  always_comb begin
    alu_sum     = ALUInA + ALUInB;
    alu_diff    = ALUInA - ALUInB;
    lt_unsigned = (ALUInA < ALUInB);
    lt_signed   = ($signed(ALUInA) < $signed(ALUInB));
  end

  // ALU operation decode; unused encodings 8-15 yield zero.
  always_comb begin
    alu_res = '0;
    unique case (ALUop)
      4'd0:    alu_res = ALUInA & ALUInB;
      4'd1:    alu_res = ALUInA | ALUInB;
      4'd2:    alu_res = alu_sum;
      4'd3:    alu_res = ALUInA ^ ALUInB;
      4'd4:    alu_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      4'd5:    alu_res = ~(ALUInA | ALUInB);
      4'd6:    alu_res = alu_diff;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
      default: alu_res = '0;
    endcase
  end

  // Zero flag looks only at the ALU, never at the mux or the register.
  always_comb begin
    isZero = (alu_res == '0);
  end

  // Result mux and next-state of the result register; reset wins over write.
  always_comb begin
    res_sel   = ResSource ? ShifterOut : alu_res;
    res_out_d = res_out_q;
    if (Reset) begin
      res_out_d = '0;
    end else if (ResWrite) begin
      res_out_d = res_sel;
    end
  end

  // Result register for the next pipeline stage.
  always_ff @(posedge CLK) begin
    res_out_q <= res_out_d;
  end

  assign ResOut = res_out_q;

`ifdef STAGE3_OVERFLOW_FLAG_EN
  // Signed overflow: add when operand signs match and the sum sign flips;
  // subtract when operand signs differ and the difference sign differs from A.
  always_comb begin
    Overflow = 1'b0;
    if (ALUop == 4'd2) begin
      Overflow = (ALUInA[WIDTH-1] == ALUInB[WIDTH-1]) &&
                 (alu_sum[WIDTH-1] != ALUInA[WIDTH-1]);
    end else if (ALUop == 4'd6) begin
      Overflow = (ALUInA[WIDTH-1] != ALUInB[WIDTH-1]) &&
                 (alu_diff[WIDTH-1] != ALUInA[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_stage3_integration.sv
// Directed self-checking bench for stage3_integration.
module tb_stage3_integration;

  logic        CLK;
  logic        Reset;
  logic [15:0] ShifterOut;
  logic [15:0] ALUInA;
  logic [15:0] ALUInB;
  logic [3:0]  ALUop;
  logic        ResSource;
  logic        ResWrite;
  logic [15:0] ResOut;
  logic        isZero;
`ifdef STAGE3_OVERFLOW_FLAG_EN
  logic        Overflow;
`endif

  int n_checks;
  int n_fail;

  stage3_integration #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .ShifterOut (ShifterOut),
    .ALUInA     (ALUInA),
    .ALUInB     (ALUInB),
    .ALUop      (ALUop),
    .ResSource  (ResSource),
    .ResWrite   (ResWrite),
`ifdef STAGE3_OVERFLOW_FLAG_EN
    .Overflow   (Overflow),
`endif
    .ResOut     (ResOut),
    .isZero     (isZero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference ALU written from the operation table.
  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] wide;
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: begin wide = {1'b0, a} + {1'b0, b}; return wide[15:0]; end
      4'd3: return a ^ b;
      4'd4: return (a < b) ? 16'd1 : 16'd0;
      4'd5: return ~(a | b);
      4'd6: begin wide = {1'b0, a} + {1'b0, ~b} + 17'd1; return wide[15:0]; end
      4'd7: begin
        if (a[15] != b[15]) return a[15] ? 16'd1 : 16'd0;
        return (a < b) ? 16'd1 : 16'd0;
      end
      default: return 16'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ResWrite = 1'b1; ResSource = 1'b1; ShifterOut = 16'hBEEF;
    ALUInA = 16'h1234; ALUInB = 16'h4321; ALUop = 4'd1;
    tick();
    tick();
    n_checks++;
    if (ResOut !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_value: ResOut=%h expected=%h", ResOut, 16'h0000);
    end
    Reset = 1'b0; ResSource = 1'b0; ALUop = 4'd0;
    ALUInA = 16'h0005; ALUInB = 16'hFFFC;
    tick();
    n_checks++;
    if (ResOut !== 16'h0004) begin
      n_fail++;
      $display("FAIL first_and: ResOut=%h expected=%h", ResOut, 16'h0004);
    end
  endtask

  task automatic test_sweep();
    logic [3:0]  ops [5];
    logic [15:0] exp_v;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd4};
    Reset = 1'b0; ResWrite = 1'b1; ResSource = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      for (int k = 0; k < 5; k++) begin
        ALUInA = 16'(i * 5);
        ALUInB = 16'hFFFF - 16'(3 * i);
        ALUop  = ops[k];
        exp_v  = ref_alu(ops[k], 16'(i * 5), 16'hFFFF - 16'(3 * i));
        tick();
        n_checks++;
        if (ResOut !== exp_v) begin
          n_fail++;
          $display("FAIL sweep i=%0d op=%0d: ResOut=%h expected=%h", i, ops[k], ResOut, exp_v);
        end
      end
    end
  endtask

  task automatic test_hand_examples();
    logic [15:0] expv [4];
    logic [3:0]  opv  [4];
    expv = '{16'hFFFD, 16'h0001, 16'h0009, 16'h0001};
    opv  = '{4'd1, 4'd2, 4'd6, 4'd4};
    ResWrite = 1'b1; ResSource = 1'b0;
    ALUInA = 16'h0005; ALUInB = 16'hFFFC;
    for (int k = 0; k < 4; k++) begin
      ALUop = opv[k];
      tick();
      n_checks++;
      if (ResOut !== expv[k]) begin
        n_fail++;
        $display("FAIL hand_i1 op=%0d: ResOut=%h expected=%h", opv[k], ResOut, expv[k]);
      end
    end
  endtask

  task automatic test_compare();
    logic [15:0] av   [6];
    logic [15:0] bv   [6];
    logic [3:0]  opv  [6];
    logic [15:0] expv [6];
    av   = '{16'h0005, 16'h0005, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    bv   = '{16'hFFFC, 16'hFFFC, 16'h0001, 16'h0001, 16'h8000, 16'h8000};
    opv  = '{4'd4,     4'd7,     4'd4,     4'd7,     4'd4,     4'd7};
    expv = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
    ResWrite = 1'b1; ResSource = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ALUInA = av[k]; ALUInB = bv[k]; ALUop = opv[k];
      tick();
      n_checks++;
      if (ResOut !== expv[k]) begin
        n_fail++;
        $display("FAIL compare_%0d op=%0d: ResOut=%h expected=%h", k, opv[k], ResOut, expv[k]);
      end
    end
  endtask

  task automatic test_mux();
    ResWrite = 1'b1; ResSource = 1'b1; ShifterOut = 16'hA5A5;
    ALUop = 4'd2; ALUInA = 16'h1234; ALUInB = 16'h1234;
    tick();
    n_checks++;
    if (ResOut !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL mux_shifter: ResOut=%h expected=%h", ResOut, 16'hA5A5);
    end
    n_checks++;
    if (isZero !== 1'b0) begin
      n_fail++;
      $display("FAIL mux_iszero: isZero=%b expected=%b", isZero, 1'b0);
    end
    // Shifter value of zero must not raise the zero flag.
    ShifterOut = 16'h0000; ALUop = 4'd3; ALUInA = 16'h00F0; ALUInB = 16'h0F00;
    tick();
    n_checks++;
    if (ResOut !== 16'h0000 || isZero !== 1'b0) begin
      n_fail++;
      $display("FAIL mux_zero_shift: ResOut=%h isZero=%b expected=0000/0", ResOut, isZero);
    end
    ResSource = 1'b0;
    tick();
    n_checks++;
    if (ResOut !== 16'h0FF0) begin
      n_fail++;
      $display("FAIL xor_alu: ResOut=%h expected=%h", ResOut, 16'h0FF0);
    end
  endtask

  task automatic test_hold();
    ResWrite = 1'b1; ResSource = 1'b0; ALUop = 4'd1;
    ALUInA = 16'h1111; ALUInB = 16'h0000;
    tick();
    n_checks++;
    if (ResOut !== 16'h1111) begin
      n_fail++;
      $display("FAIL hold_load: ResOut=%h expected=%h", ResOut, 16'h1111);
    end
    ResWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ALUInA = 16'h2222 + 16'(k); ALUop = 4'(k + 2); ResSource = k[0];
      ShifterOut = 16'h3333;
      tick();
      n_checks++;
      if (ResOut !== 16'h1111) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: ResOut=%h expected=%h", k, ResOut, 16'h1111);
      end
    end
    Reset = 1'b1; ResWrite = 1'b1; ResSource = 1'b1; ShifterOut = 16'hFFFF;
    tick();
    n_checks++;
    if (ResOut !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_priority: ResOut=%h expected=%h", ResOut, 16'h0000);
    end
    Reset = 1'b0; ResSource = 1'b0;
  endtask

  task automatic test_iszero();
    ResWrite = 1'b1; ResSource = 1'b0;
    ALUop = 4'd1; ALUInA = 16'h00AA; ALUInB = 16'h0000;
    tick();
    ALUop = 4'd6; ALUInA = 16'h7777; ALUInB = 16'h7777;
    #1;
    n_checks++;
    if (isZero !== 1'b1) begin
      n_fail++;
      $display("FAIL iszero_sub_comb: isZero=%b expected=1", isZero);
    end
    n_checks++;
    if (ResOut !== 16'h00AA) begin
      n_fail++;
      $display("FAIL iszero_pre_edge: ResOut=%h expected=%h", ResOut, 16'h00AA);
    end
    ALUop = 4'd2; ALUInA = 16'hFFFF; ALUInB = 16'h0001; Reset = 1'b1;
    #1;
    n_checks++;
    if (isZero !== 1'b1) begin
      n_fail++;
      $display("FAIL iszero_add_wrap: isZero=%b expected=1", isZero);
    end
    Reset = 1'b0;
    ALUInB = 16'h0002;
    #1;
    n_checks++;
    if (isZero !== 1'b0) begin
      n_fail++;
      $display("FAIL iszero_nonzero: isZero=%b expected=0", isZero);
    end
    ALUop = 4'd9; ALUInA = 16'hFFFF; ALUInB = 16'hFFFF;
    #1;
    n_checks++;
    if (isZero !== 1'b1) begin
      n_fail++;
      $display("FAIL iszero_unused_op: isZero=%b expected=1", isZero);
    end
    tick();
    n_checks++;
    if (ResOut !== 16'h0000) begin
      n_fail++;
      $display("FAIL unused_op_result: ResOut=%h expected=%h", ResOut, 16'h0000);
    end
    ALUop = 4'd5; ALUInA = 16'hF0F0; ALUInB = 16'h0F00;
    tick();
    n_checks++;
    if (ResOut !== 16'h000F) begin
      n_fail++;
      $display("FAIL nor_result: ResOut=%h expected=%h", ResOut, 16'h000F);
    end
  endtask

`ifdef STAGE3_OVERFLOW_FLAG_EN
  task automatic test_overflow();
    logic [15:0] av  [5];
    logic [15:0] bv  [5];
    logic [3:0]  opv [5];
    logic        exv [5];
    av  = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 16'h7FFF};
    bv  = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
    opv = '{4'd2,     4'd6,     4'd2,     4'd2,     4'd0};
    exv = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b0};
    for (int k = 0; k < 5; k++) begin
      ALUInA = av[k]; ALUInB = bv[k]; ALUop = opv[k];
      #1;
      n_checks++;
      if (Overflow !== exv[k]) begin
        n_fail++;
        $display("FAIL overflow_%0d: Overflow=%b expected=%b", k, Overflow, exv[k]);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b1; ShifterOut = '0; ALUInA = '0; ALUInB = '0;
    ALUop = '0; ResSource = 1'b0; ResWrite = 1'b0;
    test_reset();
    test_hand_examples();
    test_sweep();
    test_compare();
    test_mux();
    test_hold();
    test_iszero();
`ifdef STAGE3_OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage3_integration.md
Name: stage3_integration

Overview:
- Execute stage (stage 3) of the 16-bit JALA pipeline.
- Combinational ALU on ALUInA/ALUInB selected by ALUop, plus a 2:1 result mux that chooses between the ALU result and the shifter result.
- The chosen value is captured in the write-enabled result register ResOut for the next stage.
- isZero is the combinational zero flag of the ALU result, used for branch decisions.

Parameters:
- WIDTH, 16, datapath width of operands, shifter input and ResOut.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous active-high reset
- ShifterOut  input  WIDTH  result from shifter unit
- ALUInA  input  WIDTH  ALU operand A
- ALUInB  input  WIDTH  ALU operand B
- ALUop  input  4  ALU operation select
- ResSource  input  1  0 = ALU result, 1 = ShifterOut
- ResWrite  input  1  result register write enable
- ResOut  output  WIDTH  registered stage result
- isZero  output  1  1 when current combinational ALU result == 0

Behaviour:
- One clock (CLK); reset is synchronous and active-high (Reset). Reset sampled on rising CLK edge only.
- Reset: ResOut <= 0. Reset has priority over ResWrite.
- ALU is purely combinational. All arithmetic is modulo 2^WIDTH; carries are discarded. ALUop encoding:
  - 0: A & B
  - 1: A | B
  - 2: A + B
  - 3: A ^ B
  - 4: unsigned set-less-than; result is {0..0,1} if A < B (unsigned), else 0
  - 5: ~(A | B)
  - 6: A - B
  - 7: signed set-less-than; result is 1 if $signed(A) < $signed(B), else 0
  - 8-15: result 0
- Mux: sel = ResSource ? ShifterOut : ALU result.
- Register update on each rising CLK edge:
  - Reset=1: ResOut <= 0.
  - Else ResWrite=1: ResOut <= sel.
  - Else ResOut holds its value.
- Latency:
  - Inputs present at rising edge N appear on ResOut right after edge N (one-cycle register).
  - Changes after edge N take effect at edge N+1.
- isZero:
  - Combinational, equals (ALU result == 0).
  - Independent of ResSource, ResWrite and Reset.
  - Not registered.
- ALUop, ResSource and ResWrite may change every cycle; no handshake.
- No X propagation requirement beyond reset: after the first reset, ResOut is always defined.

Optional Feature:
- Macro STAGE3_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port Overflow (1 bit, combinational).
  - Overflow = signed two's-complement overflow of ALUop 2 (operands same sign, sum sign differs) or ALUop 6 (operands differ in sign, difference sign differs from A).
  - Overflow = 0 for all other ops.
  - Overflow does not affect ResOut or isZero.
- When undefined: no Overflow port, no related logic.

Test Plan:
- Reset=1 for 2 edges with arbitrary inputs -> ResOut=0x0000. Release; ResWrite=1, ALUop=0, A=0x0005, B=0xFFFC -> ResOut=0x0004 after next edge.
- Per-op sweep, i=1..100, A=i*5, B=0xFFFF-3i, ResWrite=1, ResSource=0, ALUop in {0,1,2,6,4} -> each cycle ResOut equals op(A,B) from the previous edge. Examples for i=1: OR=0xFFFD, ADD=0x0001, SUB=0x0009, unsigned SLT=0x0001.
- Signed vs unsigned compare: A=0x0005, B=0xFFFC -> ALUop 4 gives 1, ALUop 7 gives 0. A=0x8000, B=0x0001 -> ALUop 4 gives 0, ALUop 7 gives 1.
- ResSource=1, ShifterOut=0xA5A5, ALUop=2, A=B=0x1234 -> ResOut=0xA5A5. isZero=0 (ALU result 0x2468).
- Hold: ResOut=0x1111, then ResWrite=0 and inputs change for 3 cycles -> ResOut stays 0x1111. Reset asserted while ResWrite=1 -> ResOut=0.
- isZero: ALUop=6, A=B=0x7777 -> isZero=1 in the same cycle, before the edge. A=0xFFFF, B=0x0001, ALUop=2 -> isZero=1. With STAGE3_OVERFLOW_FLAG_EN: A=0x7FFF, B=0x0001, ALUop=2 -> Overflow=1.
